// File: rtl/sdf_butterfly_stage.sv
// Radix-2 single-path delay-feedback (DIF) butterfly stage.
// Sums leave during the second half-frame; differences recirculate through the delay line and leave during the next first half.
module sdf_butterfly_stage #(
  parameter int data_width   = 16,
  parameter int delay_length = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic                          flush,
  input  logic [2*data_width-1:0]       d_in,
  output logic [2*(data_width+1)-1:0]   d_out,
  output logic                          d_valid,
  output logic                          out_sel
);

  localparam int ew = data_width + 1;
  localparam int cw = $clog2(delay_length) + 1;
  localparam logic [cw-1:0] cnt_one  = cw'(1);
  localparam logic [cw-1:0] cnt_half = cw'(delay_length);

  logic [cw-1:0]   cnt_r;
  logic            have_diff_r;
  logic [2*ew-1:0] dly_r [delay_length];
  logic [2*ew-1:0] d_out_r;
  logic            d_valid_r;
  logic            out_sel_r;

  logic            phase_s;
  logic            accept_s;
  logic            flush_step_s;
  logic            step_s;
  logic [cw-1:0]   cnt_inc_s;
  logic [ew-1:0]   x_re_s, x_im_s, h_re_s, h_im_s;
  logic [2*ew-1:0] x_s, head_s, sum_s, diff_s, push_s;
  logic [cw-1:0]   cnt_nxt_s;
  logic            have_diff_nxt_s;
  logic [2*ew-1:0] d_out_nxt_s;
  logic            d_valid_nxt_s;
  logic            out_sel_nxt_s;

  assign phase_s      = cnt_r[cw-1];
  assign accept_s     = en && in_valid;
  assign flush_step_s = en && flush && !in_valid && have_diff_r && !phase_s;
  assign step_s       = accept_s || flush_step_s;
  assign cnt_inc_s    = cnt_r + cnt_one;

  assign x_re_s = {d_in[2*data_width-1], d_in[2*data_width-1:data_width]};
  assign x_im_s = {d_in[data_width-1], d_in[data_width-1:0]};
  assign x_s    = {x_re_s, x_im_s};
  assign head_s = dly_r[delay_length-1];
  assign h_re_s = head_s[2*ew-1:ew];
  assign h_im_s = head_s[ew-1:0];
  assign sum_s  = {h_re_s + x_re_s, h_im_s + x_im_s};
  assign diff_s = {h_re_s - x_re_s, h_im_s - x_im_s};

  // Next-state and output selection for accept, flush step and idle beats.
  always_comb begin
    cnt_nxt_s       = cnt_r;
    have_diff_nxt_s = have_diff_r;
    d_out_nxt_s     = d_out_r;
    d_valid_nxt_s   = d_valid_r;
    out_sel_nxt_s   = out_sel_r;
    push_s          = '0;
    if (!en) begin
      d_valid_nxt_s = d_valid_r;
    end else if (accept_s) begin
      cnt_nxt_s = cnt_inc_s;
      if (!phase_s) begin
        push_s = x_s;
        if (have_diff_r) begin
          d_out_nxt_s   = head_s;
          d_valid_nxt_s = 1'b1;
          out_sel_nxt_s = 1'b1;
        end else begin
          d_valid_nxt_s = 1'b0;
        end
      end else begin
        push_s        = diff_s;
        d_out_nxt_s   = sum_s;
        d_valid_nxt_s = 1'b1;
        out_sel_nxt_s = 1'b0;
        // Last sample of the frame: the stored differences become pending.
        if (&cnt_r) begin
          have_diff_nxt_s = 1'b1;
        end else begin
          have_diff_nxt_s = have_diff_r;
        end
      end
    end else if (flush_step_s) begin
      push_s        = '0;
      d_out_nxt_s   = head_s;
      d_valid_nxt_s = 1'b1;
      out_sel_nxt_s = 1'b1;
      if (cnt_inc_s == cnt_half) begin
        cnt_nxt_s       = '0;
        have_diff_nxt_s = 1'b0;
      end else begin
        cnt_nxt_s = cnt_inc_s;
      end
    end else begin
      d_valid_nxt_s = 1'b0;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= '0;
      have_diff_r <= 1'b0;
      d_out_r     <= '0;
      d_valid_r   <= 1'b0;
      out_sel_r   <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      have_diff_r <= have_diff_nxt_s;
      d_out_r     <= d_out_nxt_s;
      d_valid_r   <= d_valid_nxt_s;
      out_sel_r   <= out_sel_nxt_s;
    end
  end

  // Feedback delay line, one position per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < delay_length; i++) begin
        dly_r[i] <= '0;
      end
    end else if (step_s) begin
      dly_r[0] <= push_s;
      for (int i = 1; i < delay_length; i++) begin
        dly_r[i] <= dly_r[i-1];
      end
    end
  end

  assign d_out   = d_out_r;
  assign d_valid = d_valid_r;
  assign out_sel = out_sel_r;

endmodule
